dm_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory. It shares the memory between the single-cycle CPU load/store path and an external DMA master. CPU accesses complete combinationally in the same cycle. DMA accesses are granted as bounded bursts, and `cpu_stall` freezes the PC while the DMA owns the port. It sits between the CPU ALU/GPR data path and `dm_4k`, taking the place of the direct address/data/`DMWr` connection.

---
 rtl/dm_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory (dm_4k) between the CPU
// load/store path and an external DMA master.
//
// The CPU path is combinational. A CPU access completes in the cycle it is
// requested, unless the DMA owns the port. In that case cpu_stall holds the PC.
//
// The DMA is granted bounded bursts of up to MAX_BURST consecutive beats.
//
// Optional feature:
//   Define DM_ARB_FAIR_EN to alternate simultaneous requests in S_IDLE
//   (round-robin). Without it, the CPU has fixed priority on ties.
//
// Handshake (DMA side): a beat transfers in every cycle where dma_req and
// dma_gnt are both high. dma_req/dma_we/dma_addr/dma_wdata must stay stable
// while dma_req is high and dma_gnt is low. Read data for a granted read beat
// appears on dma_rdata with a one-cycle dma_rvalid pulse in the next cycle.
//
// Debug: dbg_state and dbg_burst_cnt expose the arbiter FSM.
module dm_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              dbg_state,
  output logic [3:0]        dbg_burst_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DMA  = 1'b1
  } state_t;

  localparam logic       OWN_CPU    = 1'b0;
  localparam logic       OWN_DMA    = 1'b1;
  localparam logic [3:0] LAST_CNT   = 4'(MAX_BURST - 1);
  localparam logic       MULTI_BEAT = (MAX_BURST > 1);

  state_t     state;
  logic [3:0] burst_cnt;
  logic       last_owner;

  logic tie_to_dma;
  logic dma_win;
  logic dma_gnt_c;
  logic cpu_gnt_c;

  // Arbitration. All grants are forced low while reset is asserted.
  always_comb begin
`ifdef DM_ARB_FAIR_EN
    tie_to_dma = (last_owner == OWN_CPU);
`else
    tie_to_dma = 1'b0;
`endif
    dma_win   = (state == S_IDLE) && dma_req && (!cpu_req || tie_to_dma);
    dma_gnt_c = reset && ((state == S_DMA) ? dma_req : dma_win);
    cpu_gnt_c = reset && (state == S_IDLE) && !dma_win && cpu_req;
  end

  // Memory port mux. With no DMA grant the CPU inputs drive the port.
  // The CPU can only write while it actually holds the grant.
  always_comb begin
    dma_gnt   = dma_gnt_c;
    cpu_stall = reset && cpu_req && !cpu_gnt_c;
    cpu_rdata = mem_dout;
    if (dma_gnt_c) begin
      mem_addr = dma_addr;
      mem_din  = dma_wdata;
      mem_we   = dma_we;
    end else begin
      mem_addr = cpu_addr;
      mem_din  = cpu_wdata;
      mem_we   = cpu_gnt_c && cpu_we;
    end
  end

  // Burst FSM, owner history and registered DMA read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      burst_cnt  <= 4'd0;
      last_owner <= OWN_DMA;
      dma_rdata  <= '0;
      dma_rvalid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dma_win && MULTI_BEAT) begin
            state     <= S_DMA;
            burst_cnt <= 4'd1;
          end
        end
        S_DMA: begin
          if (!dma_req || burst_cnt == LAST_CNT) begin
            state     <= S_IDLE;
            burst_cnt <= 4'd0;
          end else begin
            burst_cnt <= burst_cnt + 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          burst_cnt <= 4'd0;
        end
      endcase

      if (dma_gnt_c) begin
        last_owner <= OWN_DMA;
      end else if (cpu_gnt_c) begin
        last_owner <= OWN_CPU;
      end

      dma_rvalid <= dma_gnt_c && !dma_we;
      if (dma_gnt_c && !dma_we) begin
        dma_rdata <= mem_dout;
      end
    end
  end

  assign dbg_state     = state;
  assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a behavioural dm_4k model
// (asynchronous read, write on the rising edge).
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled on
// the falling edge.
module tb_dm_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] WBASE = 32'hA000_0000;

  logic              clk;
  logic              reset;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic [DATA_W-1:0] mem_dout;
  logic              dbg_state;
  logic [3:0]        dbg_burst_cnt;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout),
    .dbg_state(dbg_state), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // dm_4k model
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
  end

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic set_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the falling edge and checks the per-cycle arbiter outputs.
  task automatic expect_cycle(input string tag, input logic gnt, input logic stall,
                              input logic we, input logic st, input logic [3:0] cnt);
    @(negedge clk);
    check({tag, ".gnt"},   dma_gnt,       gnt);
    check({tag, ".stall"}, cpu_stall,     stall);
    check({tag, ".we"},    mem_we,        we);
    check({tag, ".state"}, dbg_state,     st);
    check({tag, ".cnt"},   dbg_burst_cnt, cnt);
  endtask

  logic       burst_st  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [3:0] burst_cnt [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

  initial begin
    reset = 1'b0;
    set_cpu(1'b1, 1'b1, 10'd5, 32'h0BAD_0BAD);
    set_dma(1'b1, 1'b1, 10'd5, 32'h0BAD_0BAD);

    // Reset state with both sides requesting writes
    tick();
    expect_cycle("rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("rst.rvalid", dma_rvalid, 1'b0);
    check("rst.rdata",  dma_rdata,  32'h0);
    tick();

    // CPU write then same-cycle read
    reset = 1'b1;
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    set_cpu(1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    expect_cycle("cpu_wr", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check("cpu_wr.addr", mem_addr, 32'd5);
    tick();
    set_cpu(1'b1, 1'b0, 10'd5, 32'h0);
    expect_cycle("cpu_rd", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("cpu_rd.data", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Six DMA write beats: 4-beat burst, re-arbitration in S_IDLE, 2 more
    set_cpu(1'b0, 1'b0, 10'd0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      set_dma(1'b1, 1'b1, ADDR_W'(i), WBASE + DATA_W'(i));
      expect_cycle($sformatf("dwr%0d", i), 1'b1, 1'b0, 1'b1, burst_st[i], burst_cnt[i]);
      check($sformatf("dwr%0d.addr", i), mem_addr, 32'(i));
      tick();
    end
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    expect_cycle("dwr_drop", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    tick();

    // Six DMA read beats; dma_rvalid lags each beat by one cycle
    for (int i = 0; i < 6; i++) begin
      set_dma(1'b1, 1'b0, ADDR_W'(i), 32'h0);
      expect_cycle($sformatf("drd%0d", i), 1'b1, 1'b0, 1'b0, burst_st[i], burst_cnt[i]);
      if (i == 0) begin
        check("drd0.rvalid", dma_rvalid, 1'b0);
      end else begin
        check($sformatf("drd%0d.rvalid", i), dma_rvalid, 1'b1);
        check($sformatf("drd%0d.rdata", i), dma_rdata, exp_q.pop_front());
      end
      exp_q.push_back(WBASE + DATA_W'(i));
      tick();
    end
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    expect_cycle("drd_tail", 1'b0, 1'b0, 1'b0, 1'b1, 4'd2);
    check("drd_tail.rvalid", dma_rvalid, 1'b1);
    check("drd_tail.rdata", dma_rdata, exp_q.pop_front());
    tick();

    // CPU request during a burst: stalled for exactly 3 cycles
    set_dma(1'b1, 1'b1, 10'd10, 32'h11);
    expect_cycle("stl_a", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    check("stl_a.rvalid", dma_rvalid, 1'b0);
    tick();
    set_cpu(1'b1, 1'b0, 10'd5, 32'h0);
    for (int k = 0; k < 3; k++) begin
      set_dma(1'b1, 1'b1, ADDR_W'(11 + k), 32'h11);
      expect_cycle($sformatf("stl%0d", k), 1'b1, 1'b1, 1'b1, 1'b1, 4'(k + 1));
      tick();
    end
    expect_cycle("stl_tie", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("stl_tie.addr",  mem_addr,  32'd5);
    check("stl_tie.rdata", cpu_rdata, WBASE + 32'd5);
    tick();
`ifdef DM_ARB_FAIR_EN
    expect_cycle("stl_tie2", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
`else
    expect_cycle("stl_tie2", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
`endif
    tick();

    // Quiet cycle returns the FSM to S_IDLE
    set_cpu(1'b0, 1'b0, 10'd0, 32'h0);
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    check("quiet.gnt", dma_gnt, 1'b0);
    tick();

    // dma_req dropped after 2 beats
    set_dma(1'b1, 1'b1, 10'd20, 32'h22);
    expect_cycle("drp0", 1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    tick();
    set_dma(1'b1, 1'b1, 10'd21, 32'h23);
    expect_cycle("drp1", 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
    tick();
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    set_cpu(1'b1, 1'b0, 10'd5, 32'h0);
    expect_cycle("drp2", 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    tick();
    expect_cycle("drp3", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("drp3.rdata", cpu_rdata, WBASE + 32'd5);
    tick();

    // Reset pulsed mid-burst, right after a DMA read beat
    set_cpu(1'b0, 1'b0, 10'd0, 32'h0);
    set_dma(1'b1, 1'b0, 10'd3, 32'h0);
    expect_cycle("rmb0", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    set_dma(1'b1, 1'b0, 10'd4, 32'h0);
    expect_cycle("rmb1", 1'b1, 1'b0, 1'b0, 1'b1, 4'd1);
    tick();
    check("rmb.rvalid_pre", dma_rvalid, 1'b1);
    reset = 1'b0;
    set_dma(1'b1, 1'b1, 10'd5, 32'h0BAD_0BAD);
    set_cpu(1'b1, 1'b1, 10'd5, 32'h0BAD_0BAD);
    expect_cycle("rmb_rst", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("rmb_rst.rvalid", dma_rvalid, 1'b0);
    tick();
    tick();

    // Both requesting from reset
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 10'd5, 32'h0);
    set_dma(1'b1, 1'b0, 10'd6, 32'h0);
`ifdef DM_ARB_FAIR_EN
    expect_cycle("both0", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check("both0.rdata", cpu_rdata, WBASE + 32'd5);
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cycle($sformatf("both%0d", i + 1), 1'b1, 1'b1, 1'b0, burst_st[i], burst_cnt[i]);
      tick();
    end
    expect_cycle("both5", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    expect_cycle("both6", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
`else
    for (int i = 0; i < 3; i++) begin
      expect_cycle($sformatf("both%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      check($sformatf("both%0d.rdata", i), cpu_rdata, WBASE + 32'd5);
      tick();
    end
`endif

    set_cpu(1'b0, 1'b0, 10'd0, 32'h0);
    set_dma(1'b0, 1'b0, 10'd0, 32'h0);
    tick();
    check("exp_q.empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
